// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// RF_WB_DEBUG_EN (optional) adds a debug write port that preempts arbitration.
package rf_wb_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef struct packed {
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Per-requester writeback FIFO with a combinational head output.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(FIFO_DEPTH);

  wb_req_t mem_q [FIFO_DEPTH];
  wb_req_t mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d = wr_q + PW'(1);
    end
    if (pop_ok) rd_d = rd_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two FIFOs.
// RF_WB_DEBUG_EN adds dbg_we/dbg_wa/dbg_wd, which preempt the arbiter.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [RF_AW-1:0] req0_wa,
  input  logic [RF_DW-1:0] req0_wd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [RF_AW-1:0] req1_wa,
  input  logic [RF_DW-1:0] req1_wd,
`ifdef RF_WB_DEBUG_EN
  input  logic             dbg_we,
  input  logic [RF_AW-1:0] dbg_wa,
  input  logic [RF_DW-1:0] dbg_wd,
`endif
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_wa,
  output logic [RF_DW-1:0] rf_wd,
  output logic             wb_idle
);
  wb_req_t head0, head1, dbg_req, sel_req;
  logic full0, full1, empty0, empty1;
  logic pop0, pop1, dbg_hit, sel;
  logic last_grant_q, last_grant_d;
  logic rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_wa_q, rf_wa_d;
  logic [RF_DW-1:0] rf_wd_q, rf_wd_d;

`ifdef RF_WB_DEBUG_EN
  assign dbg_hit = dbg_we;
  assign dbg_req = '{wa: dbg_wa, wd: dbg_wd};
`else
  assign dbg_hit = 1'b0;
  assign dbg_req = '0;
`endif

  rf_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst),
    .push(req0_valid), .pop(pop0),
    .din('{wa: req0_wa, wd: req0_wd}),
    .dout(head0), .full(full0), .empty(empty0)
  );

  rf_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst),
    .push(req1_valid), .pop(pop1),
    .din('{wa: req1_wa, wd: req1_wd}),
    .dout(head1), .full(full1), .empty(empty1)
  );

  assign req0_ready = !full0;
  assign req1_ready = !full1;

  // Contention goes to the requester not granted last.
  assign sel     = empty0 ? 1'b1 : (empty1 ? 1'b0 : !last_grant_q);
  assign sel_req = sel ? head1 : head0;

  always_comb begin
    pop0         = 1'b0;
    pop1         = 1'b0;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    if (dbg_hit) begin
      rf_we_d = (dbg_req.wa != '0);
      rf_wa_d = dbg_req.wa;
      rf_wd_d = dbg_req.wd;
    end else if (!empty0 || !empty1) begin
      pop0         = !sel;
      pop1         = sel;
      last_grant_d = sel;
      rf_we_d      = (sel_req.wa != '0);
      rf_wa_d      = sel_req.wa;
      rf_wd_d      = sel_req.wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign wb_idle = empty0 && empty1 && !rf_we_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a queue-based model.
// Define RF_WB_DEBUG_EN for both bench and RTL to exercise the debug port.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [4:0] req0_wa = '0, req1_wa = '0;
  logic [31:0] req0_wd = '0, req1_wd = '0;
  logic rf_we, wb_idle;
  logic [4:0] rf_wa;
  logic [31:0] rf_wd;
`ifdef RF_WB_DEBUG_EN
  logic dbg_we = 1'b0;
  logic [4:0] dbg_wa = '0;
  logic [31:0] dbg_wd = '0;
`endif

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_wa(req0_wa), .req0_wd(req0_wd),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_wa(req1_wa), .req1_wd(req1_wd),
`ifdef RF_WB_DEBUG_EN
    .dbg_we(dbg_we), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
`endif
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .wb_idle(wb_idle)
  );

  always #5 clk = ~clk;

  // Stand-in for REG_FILE, committing whatever the port presents.
  logic [31:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we && rf_wa != 5'd0) regs[rf_wa] <= rf_wd;

  int checks = 0;
  int errors = 0;

  // Model: pending source writes, FIFO contents, last winner, expected port.
  wb_req_t pend0[$], pend1[$], mq0[$], mq1[$];
  int m_last = 1;
  logic e_we = 1'b0;
  logic [4:0] e_wa = '0;
  logic [31:0] e_wd = '0;
  bit rnd = 1'b0;
  bit dbg_now = 1'b0;
  wb_req_t dbg_item;
  int wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(e_we));
    chk({tag, ".rf_wa"}, 32'(rf_wa), 32'(e_wa));
    chk({tag, ".rf_wd"}, rf_wd, e_wd);
    chk({tag, ".rdy0"}, 32'(req0_ready), 32'(mq0.size() < DEPTH));
    chk({tag, ".rdy1"}, 32'(req1_ready), 32'(mq1.size() < DEPTH));
    chk({tag, ".idle"}, 32'(wb_idle),
        32'(mq0.size() == 0 && mq1.size() == 0 && !e_we));
  endtask

  task automatic step(input string tag);
    bit v0, v1, a0, a1;
    int g;
    wb_req_t h;
    v0 = pend0.size() > 0 && (!rnd || $urandom_range(0, 1) == 1);
    v1 = pend1.size() > 0 && (!rnd || $urandom_range(0, 1) == 1);
    req0_valid = v0;
    req1_valid = v1;
    if (v0) begin req0_wa = pend0[0].wa; req0_wd = pend0[0].wd; end
    if (v1) begin req1_wa = pend1[0].wa; req1_wd = pend1[0].wd; end
`ifdef RF_WB_DEBUG_EN
    dbg_we = dbg_now;
    dbg_wa = dbg_item.wa;
    dbg_wd = dbg_item.wd;
`endif
    @(posedge clk);
    a0 = v0 && mq0.size() < DEPTH;
    a1 = v1 && mq1.size() < DEPTH;
    g = -1;
    if (dbg_now) begin
      e_we = dbg_item.wa != 0; e_wa = dbg_item.wa; e_wd = dbg_item.wd;
    end else begin
      if (mq0.size() > 0 && mq1.size() > 0) g = 1 - m_last;
      else if (mq0.size() > 0) g = 0;
      else if (mq1.size() > 0) g = 1;
      if (g >= 0) begin
        h = (g == 0) ? mq0.pop_front() : mq1.pop_front();
        m_last = g;
        e_we = h.wa != 0; e_wa = h.wa; e_wd = h.wd;
      end else e_we = 1'b0;
    end
    if (a0) mq0.push_back(pend0.pop_front());
    if (a1) mq1.push_back(pend1.pop_front());
    #1;
    if (rf_we) wlog.push_back(int'(rf_wa));
    chk_all(tag);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifdef RF_WB_DEBUG_EN
    dbg_we = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mq0.delete(); mq1.delete(); pend0.delete(); pend1.delete();
    m_last = 1; e_we = 1'b0; e_wa = '0; e_wd = '0;
    chk_all("reset");
    rst = 1'b0;
  endtask

  function automatic wb_req_t mk(input int wa, input logic [31:0] wd);
    wb_req_t r;
    r.wa = 5'(wa);
    r.wd = wd;
    return r;
  endfunction

  initial begin
    int exp_seq[8];
    dbg_item = '0;
    // Reset then idle
    do_reset();
    repeat (2) step("idle");

    // Single write: visible one cycle after the push, committed the next
    pend0.push_back(mk(1, 32'h1000_0000));
    step("single.push");
    step("single.wr");
    chk("single.wa", 32'(rf_wa), 32'd1);
    step("single.after");
    chk("single.regfile", regs[1], 32'h1000_0000);

    // Contention: strict alternation starting with requester 0
    do_reset();
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(2 + i, 32'hA000_0000 + 32'(i)));
      pend1.push_back(mk(6 + i, 32'hB000_0000 + 32'(i)));
    end
    repeat (12) step("contend");
    exp_seq = '{2, 6, 3, 7, 4, 8, 5, 9};
    chk("contend.count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      chk("contend.seq", 32'(wlog[i]), 32'(exp_seq[i]));

    // x0 write is popped but never enabled
    pend1.push_back(mk(0, 32'hDEAD_BEEF));
    repeat (3) step("x0");
    chk("x0.regfile", regs[0], 32'h0);

`ifdef RF_WB_DEBUG_EN
    // Debug preemption while both FIFOs hold entries
    do_reset();
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(mk(10 + i, 32'hC000_0000 + 32'(i)));
      pend1.push_back(mk(20 + i, 32'hD000_0000 + 32'(i)));
    end
    repeat (3) step("dbg.pre");
    dbg_item = mk(31, 32'hCAFE_0000);
    dbg_now = 1'b1;
    step("dbg.hit");
    dbg_now = 1'b0;
    chk("dbg.wa", 32'(rf_wa), 32'd31);
    repeat (8) step("dbg.post");
`endif

    // Randomized traffic, including x0 destinations
    do_reset();
    rnd = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (pend0.size() < 3 && $urandom_range(0, 3) == 0)
        pend0.push_back(mk($urandom_range(0, 31), $urandom));
      if (pend1.size() < 3 && $urandom_range(0, 3) == 0)
        pend1.push_back(mk($urandom_range(0, 31), $urandom));
`ifdef RF_WB_DEBUG_EN
      dbg_now = ($urandom_range(0, 15) == 0);
      dbg_item = mk($urandom_range(0, 31), $urandom);
`endif
      step("random");
    end
`ifdef RF_WB_DEBUG_EN
    dbg_now = 1'b0;
`endif
    rnd = 1'b0;

    // Reset mid-burst: fill both FIFOs, reset, then expect silence
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(1 + i, $urandom));
      pend1.push_back(mk(11 + i, $urandom));
    end
    step("burst");
    step("burst");
    do_reset();
    wlog.delete();
    repeat (4) step("postrst");
    chk("postrst.nowrites", 32'(wlog.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the 32×32 register file (REG_FILE). It shares the single write port (rf_we/rf_wa/rf_wd) between two writeback requesters, typically the ALU-result path and the load-data path. Each requester is buffered in its own small FIFO, so short bursts are absorbed. Queued writes are drained one per cycle under round-robin arbitration, and the write-port outputs are driven from registers.

## Interface
- FIFO_DEPTH, default 2: entries per requester FIFO; power of two, ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 FIFO not full.
- req0_wa  in  5  requester 0 destination register.
- req0_wd  in  32  requester 0 write data.
- req1_valid / req1_ready / req1_wa / req1_wd: same as requester 0, for requester 1.
- rf_we  out  1  write enable to REG_FILE.
- rf_wa  out  5  write address to REG_FILE.
- rf_wd  out  32  write data to REG_FILE.
- wb_idle  out  1  both FIFOs empty and rf_we low.
- dbg_we / dbg_wa (5) / dbg_wd (32)  in: debug write, present only with RF_WB_DEBUG_EN.

## Operation
- Handshake: a transfer occurs on a rising edge where reqN_valid and reqN_ready are both 1; the {wa, wd} pair is pushed into FIFO N.
- reqN_ready = !fullN. It depends only on the FIFO count, not on a pop in the same cycle. A full FIFO therefore refuses a push even in a cycle where it is being popped.
- Arbiter state: last_grant (1 bit) holds the index of the most recently granted requester.
- Grant rule, evaluated each cycle:
  - Neither FIFO non-empty: no grant.
  - Exactly one FIFO non-empty: grant it.
  - Both non-empty: grant !last_grant.
- On a grant:
  - Pop the granted FIFO head.
  - Set last_grant to the granted index.
  - Register rf_we=1, rf_wa=head.wa, rf_wd=head.wd.
- No grant: rf_we=0. rf_wa and rf_wd hold their last values.
- Register x0 writes: a head with wa==0 is granted and popped normally, but rf_we is registered 0, so the write is discarded. last_grant still updates.
- Ordering:
  - Writes from the same requester reach REG_FILE in push order.
  - There is no cross-requester ordering guarantee.
- Reset mid-operation: both FIFOs are flushed and any in-flight write is lost. Upstream must not depend on writes pending at reset.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, last_grant=1 (so requester 0 wins the first contention), both FIFOs empty, req0_ready=req1_ready=1, wb_idle=1.
- Latency into an empty, uncontended FIFO:
  - Push at edge N.
  - Grant at edge N+1; rf_we is high during cycle N+1.
  - REG_FILE commits the write at edge N+2.
- Throughput: one write per cycle total. Under sustained contention each requester gets 1/2.
- With FIFO_DEPTH=2 and both requesters pushing every cycle, each requester's ready drops within 4 cycles. Pushes then resume alternately as entries drain.
- wb_idle is combinational from the FIFO counts and the registered rf_we.

## Configuration
- RF_WB_DEBUG_EN defined:
  - Adds the dbg_we, dbg_wa and dbg_wd ports.
  - dbg_we=1 preempts the arbiter that cycle: the debug write is registered onto rf_*.
  - No FIFO is popped and last_grant is unchanged.
  - The FIFOs keep accepting pushes while preempted.
  - A debug write to x0 is discarded like any other.
- RF_WB_DEBUG_EN undefined: the debug ports are absent and arbitration is purely round-robin.

## Structure
- Package rf_wb_pkg:
  - RF_AW=5, RF_DW=32.
  - typedef wb_req_t {logic [RF_AW-1:0] wa; logic [RF_DW-1:0] wd;}.
- Sub-module rf_wb_fifo:
  - Synchronous FIFO with async reset, parameterised by FIFO_DEPTH.
  - Ports: push, pop, din, dout (head, combinational), full, empty.
  - Instantiated twice.
- Top level contains only the grant logic, last_grant and the rf_* output registers.

## Test plan
- Reset then idle: after rst deasserts, rf_we=0, rf_wa=0, rf_wd=0, wb_idle=1, both readys=1.
- Single write: push req0 (wa=1, wd=32'h10000000) at edge N → rf_we=1, rf_wa=1, rf_wd=32'h10000000 during cycle N+1. REG_FILE reads back 32'h10000000 on rf_rd0 after edge N+2.
- Contention: req0 pushes wa=2..5 and req1 pushes wa=6..9, all back-to-back → rf_wa sequence 2,6,3,7,4,8,5,9. Each ready deasserts when its FIFO holds 2 entries.
- x0 discard: push req1 (wa=0, wd=32'hDEADBEEF) → FIFO pops, rf_we stays 0, and register 0 still reads 0.
- Reset mid-burst: fill both FIFOs, then assert rst for 1 cycle → no further rf_we, wb_idle=1, readys=1.
- (RF_WB_DEBUG_EN) Preemption: dbg_we=1 (wa=31, wd=32'hCAFE0000) while both FIFOs are non-empty → that cycle rf_wa=31. The round-robin sequence then resumes unchanged.
